// File: rtl/acc8_pkg.sv
// Shared types and defaults for the acc8 accumulate stage.
// The saturating build is selected with ACC8_SATURATE_EN (see acc8_addsub).
package acc8_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned NDefault = 4;
  localparam int unsigned WDefault = 10;

  // Counter must be able to hold the value N itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CntWDefault = cnt_width(NDefault);

endpackage

// File: rtl/acc8_addsub.sv
// Combinational add/subtract of an 8-bit operand into a W-bit accumulator.
// Define ACC8_SATURATE_EN to clamp at 0 / 2^W-1 instead of wrapping.
module acc8_addsub
  import acc8_pkg::*;
#(
  parameter int unsigned W = WDefault
) (
  input  logic [W-1:0] acc_i,
  input  logic [7:0]   opnd_i,
  input  logic         sub_i,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] ext;
  logic [W-1:0] opb;

  assign ext = W'(opnd_i);
  // Subtract is acc + ~I + 1, with the +1 supplied as carry-in.
  assign opb = sub_i ? ~ext : ext;

`ifdef ACC8_SATURATE_EN
  logic [W:0] raw;

  assign raw = {1'b0, acc_i} + {1'b0, opb} + {{W{1'b0}}, sub_i};

  // Carry out on add means overflow; no carry out on subtract means borrow.
  always_comb begin
    if (!sub_i && raw[W]) begin
      nxt_o = '1;
    end else if (sub_i && !raw[W]) begin
      nxt_o = '0;
    end else begin
      nxt_o = raw[W-1:0];
    end
  end
`else
  assign nxt_o = acc_i + opb + W'(sub_i);
`endif

endmodule

// File: rtl/acc8_stage.sv
// Accumulates N signed-by-SUB operands into a W-bit result with valid/ready handshakes.
// Saturating arithmetic when ACC8_SATURATE_EN is defined, wrapping otherwise.
module acc8_stage
  import acc8_pkg::*;
#(
  parameter int unsigned N = NDefault,
  parameter int unsigned W = WDefault
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic [7:0]   I,
  input  logic         SUB,
  input  logic         I_VALID,
  output logic         I_READY,
  input  logic         CLR,
  output logic [W-1:0] O,
  output logic         O_VALID,
  input  logic         O_READY
);

  localparam int unsigned    CntW    = cnt_width(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N);

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    o_q, o_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ov_q, ov_d;

  logic            rdy;
  logic            accept;
  logic            fresh;
  logic [W-1:0]    base;
  logic [W-1:0]    sum;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    case (state_q)
      StHold:  rdy = O_READY;
      default: rdy = 1'b1;
    endcase
  end

  // Held low while in reset so nothing upstream sees a ready in that window.
  assign I_READY = ASYNCRESETN & rdy;
  assign accept  = I_VALID & rdy;

  // From IDLE or HOLD an accepted operand opens a new accumulation from zero.
  assign fresh   = (state_q != StAccum);
  assign base    = fresh ? '0 : acc_q;
  assign cnt_inc = fresh ? CntW'(1) : cnt_q + 1'b1;

  acc8_addsub #(
    .W(W)
  ) u_addsub (
    .acc_i  (base),
    .opnd_i (I),
    .sub_i  (SUB),
    .nxt_o  (sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    ov_d    = ov_q;
    if (CLR) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      o_d     = '0;
      ov_d    = 1'b0;
    end else if (accept) begin
      // An accept in HOLD implies O_READY, so the held result is consumed too.
      acc_d = sum;
      cnt_d = cnt_inc;
      if (cnt_inc == CntLast) begin
        state_d = StHold;
        o_d     = sum;
        ov_d    = 1'b1;
      end else begin
        state_d = StAccum;
        o_d     = '0;
        ov_d    = 1'b0;
      end
    end else if (state_q == StHold && O_READY) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      o_d     = '0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
    end
  end

  assign O       = o_q;
  assign O_VALID = ov_q;

endmodule
